joy_serial_reader: RTL and testbench

JOY_SERIAL_READER -- requirements
Module: joy_serial_reader

---
 rtl/joy_serial_reader.sv | 151 +++++++++++++++
 tb/tb_joy_serial_reader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_reader.sv
// joy_serial_reader: polls an external '165-style pad shift register.
// Alternates JOY_SELECT every frame and publishes an active-high FRAME1/FRAME0 pair.
module joy_serial_reader #(
    parameter int unsigned CLK_DIV = 8,
    parameter int unsigned NBITS   = 16,
    parameter int unsigned SETTLE  = 4
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             JOY_DATA,
    output logic             JOY_CLK,
    output logic             JOY_LOAD,
    output logic             JOY_SELECT,
    output logic [NBITS-1:0] JOY_FRAME1,
    output logic [NBITS-1:0] JOY_FRAME0,
    output logic             JOY_VALID
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned SET_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_SETTLE   = 3'd4
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [SET_W-1:0] settle_q;
    logic [NBITS-1:0] shift_q;
    logic [NBITS-1:0] frame1_q;
    logic [NBITS-1:0] frame0_q;
    logic             clk_q;
    logic             load_q;
    logic             sel_q;
    logic             valid_q;
    logic             tick_c;

    // Last cycle of the current phase
    assign tick_c = (cnt_q == CNT_W'(CLK_DIV - 1));

    // Phase counter: runs 0..CLK_DIV-1 in every active state, parked at zero in IDLE
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (state_q == ST_IDLE || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Frame sequencer with all pad-facing and result outputs held in flops
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            shift_q  <= '0;
            frame1_q <= '0;
            frame0_q <= '0;
            clk_q    <= 1'b1;
            load_q   <= 1'b1;
            sel_q    <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ENABLE) begin
                        state_q <= ST_LOAD;
                        load_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (tick_c) begin
                        state_q <= ST_SHIFT_LO;
                        load_q  <= 1'b1;
                        clk_q   <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick_c) begin
                        for (int unsigned i = 0; i < NBITS; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                shift_q[i] <= ~JOY_DATA;
                            end
                        end
                        state_q <= ST_SHIFT_HI;
                        clk_q   <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick_c) begin
                        if (idx_q < IDX_W'(NBITS - 1)) begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_SHIFT_LO;
                            clk_q   <= 1'b0;
                        end else begin
                            // Publish the whole frame at once; VALID marks a complete pair
                            if (sel_q) begin
                                frame1_q <= shift_q;
                            end else begin
                                frame0_q <= shift_q;
                                valid_q  <= 1'b1;
                            end
                            sel_q    <= ~sel_q;
                            settle_q <= '0;
                            state_q  <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tick_c) begin
                        if (settle_q == SET_W'(SETTLE - 1)) begin
                            if (ENABLE) begin
                                state_q <= ST_LOAD;
                                load_q  <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                                sel_q   <= 1'b1;
                            end
                        end else begin
                            settle_q <= settle_q + SET_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    clk_q   <= 1'b1;
                    load_q  <= 1'b1;
                end
            endcase
        end
    end

    assign JOY_CLK    = clk_q;
    assign JOY_LOAD   = load_q;
    assign JOY_SELECT = sel_q;
    assign JOY_FRAME1 = frame1_q;
    assign JOY_FRAME0 = frame0_q;
    assign JOY_VALID  = valid_q;

endmodule

// File: tb/tb_joy_serial_reader.sv
// tb_joy_serial_reader: randomized pad contents against a behavioural '165 pad model,
// with frame timing derived from the phase-count formula.
`timescale 1ns/1ps
module tb_joy_serial_reader;

    localparam int unsigned A_DIV    = 8;
    localparam int unsigned A_N      = 16;
    localparam int unsigned A_S      = 4;
    localparam int unsigned A_ACTIVE = (1 + 2 * A_N) * A_DIV;
    localparam int unsigned A_PERIOD = (1 + 2 * A_N + A_S) * A_DIV;
    localparam int unsigned B_DIV    = 2;
    localparam int unsigned B_N      = 1;
    localparam int unsigned B_S      = 1;
    localparam int unsigned B_PERIOD = (1 + 2 * B_N + B_S) * B_DIV;
    localparam int unsigned LIMIT    = 4000;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;

    logic           a_en = 1'b0;
    logic           a_data, a_clk, a_load, a_sel, a_valid;
    logic [A_N-1:0] a_f1, a_f0;
    logic           b_en = 1'b0;
    logic           b_data, b_clk, b_load, b_sel, b_valid;
    logic [B_N-1:0] b_f1, b_f0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc;

    always #5 CLOCK_50 = ~CLOCK_50;

    joy_serial_reader u_dut_a (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .ENABLE    (a_en),
        .JOY_DATA  (a_data),
        .JOY_CLK   (a_clk),
        .JOY_LOAD  (a_load),
        .JOY_SELECT(a_sel),
        .JOY_FRAME1(a_f1),
        .JOY_FRAME0(a_f0),
        .JOY_VALID (a_valid)
    );

    joy_serial_reader #(.CLK_DIV(B_DIV), .NBITS(B_N), .SETTLE(B_S)) u_dut_b (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .ENABLE    (b_en),
        .JOY_DATA  (b_data),
        .JOY_CLK   (b_clk),
        .JOY_LOAD  (b_load),
        .JOY_SELECT(b_sel),
        .JOY_FRAME1(b_f1),
        .JOY_FRAME0(b_f0),
        .JOY_VALID (b_valid)
    );

    // '165 pad model: parallel load while LOAD is low, shift towards bit0 on each JOY_CLK rise
    logic [A_N-1:0] a_pad1, a_pad0, a_sr;
    logic [B_N-1:0] b_pad1, b_pad0, b_sr;
    logic           a_clk_prev, b_clk_prev;

    always @(posedge CLOCK_50) begin
        a_clk_prev <= a_clk;
        if (!a_load)                  a_sr <= a_sel ? a_pad1 : a_pad0;
        else if (a_clk && !a_clk_prev) a_sr <= a_sr >> 1;
        b_clk_prev <= b_clk;
        if (!b_load)                  b_sr <= b_sel ? b_pad1 : b_pad0;
        else if (b_clk && !b_clk_prev) b_sr <= b_sr >> 1;
    end
    assign a_data = a_sr[0];
    assign b_data = b_sr[0];

    // Cycle count since reset release
    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Waveform monitor on the default instance: pulse widths, pulse counts, quiet gap
    int unsigned m_load_run, m_clk_run, m_quiet, m_clk_cnt, m_load_pulses;
    int unsigned m_load_bad, m_clk_bad, m_frame_bad, m_gap_bad, m_gap_checks, m_valids;
    logic        m_prev_load, m_prev_clk;
    bit          m_gap_en = 1'b0;

    always @(negedge CLOCK_50) begin
        if (!RESET_N) begin
            m_load_run <= 0; m_clk_run <= 0; m_quiet <= 0; m_clk_cnt <= 0;
            m_load_pulses <= 0; m_load_bad <= 0; m_clk_bad <= 0; m_frame_bad <= 0;
            m_gap_bad <= 0; m_gap_checks <= 0; m_valids <= 0;
            m_prev_load <= 1'b1; m_prev_clk <= 1'b1;
        end else begin
            m_prev_load <= a_load;
            m_prev_clk  <= a_clk;
            if (a_valid) m_valids <= m_valids + 1;
            m_quiet <= (a_load && a_clk) ? m_quiet + 1 : 0;
            if (!a_load) m_load_run <= m_load_run + 1;
            else if (!m_prev_load) begin
                m_load_pulses <= m_load_pulses + 1;
                if (m_load_run != A_DIV) m_load_bad <= m_load_bad + 1;
                m_load_run <= 0;
            end
            if (!a_clk) m_clk_run <= m_clk_run + 1;
            else if (!m_prev_clk) begin
                m_clk_cnt <= m_clk_cnt + 1;
                if (m_clk_run != A_DIV) m_clk_bad <= m_clk_bad + 1;
                m_clk_run <= 0;
            end
            if (!a_load && m_prev_load) begin
                m_clk_cnt <= 0;
                if (m_gap_en && m_load_pulses != 0) begin
                    m_gap_checks <= m_gap_checks + 1;
                    if (m_quiet != A_DIV * (A_S + 1)) m_gap_bad <= m_gap_bad + 1;
                    if (m_clk_cnt != A_N) m_frame_bad <= m_frame_bad + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_valid(input bit use_b, input string tag, output int unsigned at);
        bit seen = 1'b0;
        at = 0;
        for (int i = 0; i < int'(LIMIT) && !seen; i++) begin
            @(negedge CLOCK_50);
            if (use_b ? b_valid : a_valid) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_load_low(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < int'(LIMIT) && !seen; i++) begin
            @(negedge CLOCK_50);
            if (!a_load) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_clk_falls(input int unsigned n, input string tag);
        int unsigned falls = 0;
        logic        prev  = a_clk;
        for (int i = 0; i < int'(LIMIT) && falls < n; i++) begin
            @(negedge CLOCK_50);
            if (prev && !a_clk) falls++;
            prev = a_clk;
        end
        check(tag, falls, n);
    endtask

    logic [A_N-1:0] exp1, exp0;
    logic [B_N-1:0] bexp1, bexp0;
    int unsigned    vcyc, last_v, n_load, n_val;

    initial begin
        a_pad1 = 16'hFFFE;
        a_pad0 = 16'h7FFF;
        b_pad1 = '0;
        b_pad0 = '0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_clk",    32'(a_clk),   32'd1);
        check("rst_load",   32'(a_load),  32'd1);
        check("rst_sel",    32'(a_sel),   32'd1);
        check("rst_f1",     32'(a_f1),    32'd0);
        check("rst_f0",     32'(a_f0),    32'd0);
        check("rst_valid",  32'(a_valid), 32'd0);

        // Directed pair: bit0 pressed on select=1, bit15 pressed on select=0
        a_en     = 1'b1;
        m_gap_en = 1'b1;
        RESET_N  = 1'b1;
        @(negedge CLOCK_50);
        check("first_load_low", 32'(a_load), 32'd0);
        check("first_load_cyc", cyc, 32'd1);
        while (cyc < A_ACTIVE) @(negedge CLOCK_50);
        check("f1_not_early", 32'(a_f1), 32'd0);
        @(negedge CLOCK_50);
        check("f1_dir",     32'(a_f1),  32'h0001);
        check("sel_after1", 32'(a_sel), 32'd0);
        check("f0_not_yet", 32'(a_f0),  32'd0);
        wait_valid(1'b0, "valid_dir_seen", vcyc);
        check("valid_dir_cyc", vcyc, 1 + A_PERIOD + A_ACTIVE);
        check("f0_dir",     32'(a_f0),  32'h8000);
        check("f1_hold",    32'(a_f1),  32'h0001);
        check("sel_after2", 32'(a_sel), 32'd1);
        exp0   = 16'h8000;
        last_v = vcyc;
        @(negedge CLOCK_50);
        check("valid_one_cycle", 32'(a_valid), 32'd0);

        // Random pad contents, pair by pair
        for (int k = 0; k < 3; k++) begin
            a_pad1 = A_N'($urandom);
            a_pad0 = A_N'($urandom);
            exp1   = ~a_pad1;
            exp0   = ~a_pad0;
            wait_valid(1'b0, "valid_rnd_seen", vcyc);
            check("f1_rnd",     32'(a_f1), 32'(exp1));
            check("f0_rnd",     32'(a_f0), 32'(exp0));
            check("pair_period", vcyc - last_v, 2 * A_PERIOD);
            last_v = vcyc;
        end
        #1;
        check("mon_load_pulses", m_load_pulses, 32'd8);
        check("mon_load_width",  m_load_bad,    32'd0);
        check("mon_clk_width",   m_clk_bad,     32'd0);
        check("mon_clk_count",   m_frame_bad,   32'd0);
        check("mon_gap",         m_gap_bad,     32'd0);
        check("mon_gap_checks",  m_gap_checks,  32'd7);
        check("mon_valids",      m_valids,      32'd4);

        // ENABLE drops during bit 5 of a select=1 frame
        m_gap_en = 1'b0;
        a_pad1   = A_N'($urandom);
        exp1     = ~a_pad1;
        n_load   = m_load_pulses;
        n_val    = m_valids;
        wait_load_low("drop_load_seen");
        wait_clk_falls(6, "drop_bit5_seen");
        a_en = 1'b0;
        repeat (A_PERIOD + 100) @(negedge CLOCK_50);
        check("drop_f1",    32'(a_f1),   32'(exp1));
        check("drop_f0",    32'(a_f0),   32'(exp0));
        check("drop_sel",   32'(a_sel),  32'd1);
        check("drop_load",  32'(a_load), 32'd1);
        check("drop_clk",   32'(a_clk),  32'd1);
        #1;
        check("drop_no_valid",   m_valids,      n_val);
        check("drop_one_frame",  m_load_pulses, n_load + 1);

        // Asynchronous reset during SHIFT_LO of bit 9
        a_pad1 = A_N'($urandom);
        a_pad0 = A_N'($urandom);
        exp1   = ~a_pad1;
        exp0   = ~a_pad0;
        a_en   = 1'b1;
        wait_load_low("rst_load_seen");
        wait_clk_falls(10, "rst_bit9_seen");
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_clk",   32'(a_clk),   32'd1);
        check("mid_rst_load",  32'(a_load),  32'd1);
        check("mid_rst_sel",   32'(a_sel),   32'd1);
        check("mid_rst_f1",    32'(a_f1),    32'd0);
        check("mid_rst_f0",    32'(a_f0),    32'd0);
        check("mid_rst_valid", 32'(a_valid), 32'd0);
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        check("restart_load_low", 32'(a_load), 32'd0);
        while (cyc < A_ACTIVE) @(negedge CLOCK_50);
        check("restart_f1_clean", 32'(a_f1), 32'd0);
        wait_valid(1'b0, "restart_valid_seen", vcyc);
        check("restart_valid_cyc", vcyc, 1 + A_PERIOD + A_ACTIVE);
        check("restart_f1", 32'(a_f1), 32'(exp1));
        check("restart_f0", 32'(a_f0), 32'(exp0));

        // Minimal instance: CLK_DIV=2, NBITS=1, SETTLE=1
        b_pad1 = B_N'($urandom);
        b_pad0 = B_N'($urandom);
        b_en   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bexp1 = ~b_pad1;
            bexp0 = ~b_pad0;
            wait_valid(1'b1, "b_valid_seen", vcyc);
            check("b_f1", 32'(b_f1), 32'(bexp1));
            check("b_f0", 32'(b_f0), 32'(bexp0));
            if (k > 0) check("b_pair_period", vcyc - last_v, 2 * B_PERIOD);
            last_v = vcyc;
            b_pad1 = B_N'($urandom);
            b_pad0 = B_N'($urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not reach its summary, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
